b01_resp_misr: RTL
==================

Name: b01_resp_misr

Overview:
- Downstream BIST response compactor for the b01 serial comparator.
- Captures b01's outp and overflw each qualified clock into a multiple-input signature register (MISR) for a programmed number of samples.
- Then compares the signature against a golden value and reports pass/fail.
- Sits between the b01 core and the BIST controller in the per-scan BIST wrapper.

Parameters:
- WIDTH, 8: MISR width in bits, minimum 2.
- POLY, 8'h1D: feedback polynomial tap mask, bit i set means x^i; the x^WIDTH term is implicit. The default is x^8+x^4+x^3+x^2+1.
- SEED, 8'h00: signature value loaded on start.
- TEST_LEN, 10: number of qualified samples per run, minimum 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a compaction run.
- sample_en  in  1  qualifies capture of outp/overflw in this cycle.
- outp  in  1  b01 outp.
- overflw  in  1  b01 overflw.
- golden_sig  in  WIDTH  expected signature; sampled at run end.
- busy  out  1  high while a run is in progress.
- done  out  1  high once a run has completed; held until the next start.
- pass  out  1  signature match result; valid when done=1.
- signature  out  WIDTH  current MISR contents.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, signature=SEED, counter=0, busy=0, done=0, pass=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN next cycle; signature<=SEED, counter<=0, busy<=1, done<=0, pass<=0.
  - sample_en is ignored in IDLE.
- RUN:
  - Each cycle with sample_en=1 performs one MISR update and counter+1.
  - Cycles with sample_en=0 hold all state (stall).
  - When sample_en=1 and counter==TEST_LEN-1, the update is applied and the next state is DONE.
  - On that same edge: busy<=0, done<=1, pass<=(next_signature==golden_sig).
  - Latency: done rises on the edge that takes the TEST_LEN-th sample.
- DONE:
  - All state is held; signature is frozen.
  - start=1 restarts exactly as from IDLE; done and pass clear on that edge.
- start while in RUN is ignored; there is no restart mid-run.
- MISR update, with fb = signature[WIDTH-1] and d = WIDTH-bit vector with d[0]=outp, d[1]=overflw, all other bits 0:
  - next_signature = {signature[WIDTH-2:0],1'b0} XOR (fb ? POLY : 0) XOR d
- Counter:
  - width is clog2(TEST_LEN+1);
  - it never exceeds TEST_LEN-1 in RUN;
  - it is not advanced in IDLE or DONE.
- Simultaneous start and sample_en in IDLE/DONE: start wins; that cycle's sample is not captured. The first capture is the next cycle.
- Reset asserted mid-run: the run is abandoned immediately and the block returns to IDLE with reset values. No partial done or pass is produced.
- X on outp/overflw while sample_en=0 must not corrupt the signature.

Decomposition:
- Shared package bist_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the default POLY and SEED constants;
  - a function misr_next(sig, d, poly), reused by later compactors in the wrapper.
- One natural sub-module, misr_core:
  - owns the WIDTH-bit register;
  - takes load (loads SEED) and shift (one update step) controls;
  - is driven by the FSM in b01_resp_misr.

Test Plan:
- Reset, then start with golden_sig=8'h00 and 10 samples of outp=0, overflw=0 -> done=1 and busy=0 after the 10th sample; signature=8'h00, pass=1.
- TEST_LEN=1, SEED=8'h80, one sample with zero inputs -> signature=8'h1D. With overflw=1 instead -> signature=8'h1F.
- TEST_LEN=2, SEED=0; sample 1 outp=1, sample 2 all zero -> signature=8'h02. With golden_sig=8'h03 -> pass=0 and done=1.
- Stall: within TEST_LEN=10, drop sample_en for 5 cycles mid-run -> signature is held during the stall; done rises only after the 10th qualified sample; the final signature equals the unstalled run.
- Start in RUN at sample 4 -> ignored, the run completes normally. Then start in DONE together with sample_en=1 -> done clears, signature=SEED, and the coincident sample is not captured.
- Assert reset=0 at sample 6 of 10 -> busy=0, done=0, pass=0, signature=SEED immediately. A subsequent full run gives the correct result.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared BIST definitions: compactor FSM states, default
// polynomial/seed constants and the generic MISR step function.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

    localparam logic [7:0] DEF_POLY = 8'h1D;
    localparam logic [7:0] DEF_SEED = 8'h00;

    // Widest MISR any compactor in the wrapper may use.
    localparam int MISR_MAX_W = 64;

    typedef logic [MISR_MAX_W-1:0] misr_vec_t;

    // One MISR step of width w: shift left, fold the MSB back through
    // the tap mask, then inject the parallel data word.
    function automatic misr_vec_t misr_next(
        input misr_vec_t   sig,
        input misr_vec_t   d,
        input misr_vec_t   poly,
        input int unsigned w
    );
        misr_vec_t one;
        misr_vec_t mask;
        misr_vec_t top;
        misr_vec_t nxt;
        one  = misr_vec_t'(1);
        mask = (w >= MISR_MAX_W) ? '1 : ((one << w) - one);
        top  = one << (w - 1);
        nxt  = (sig << 1) ^ (((sig & top) != '0) ? poly : '0) ^ d;
        return nxt & mask;
    endfunction

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: loads SEED on load, takes one
// compaction step on shift, otherwise holds.
module misr_core
    import bist_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] sig_next
);

    misr_vec_t sig_w;
    misr_vec_t d_w;
    misr_vec_t poly_w;
    misr_vec_t nxt_w;

    // Widen operands into the shared step function's vector type.
    always_comb begin
        sig_w              = '0;
        d_w                = '0;
        poly_w             = '0;
        sig_w[WIDTH-1:0]   = sig;
        d_w[WIDTH-1:0]     = d;
        poly_w[WIDTH-1:0]  = POLY;
        nxt_w              = misr_next(sig_w, d_w, poly_w, WIDTH);
    end

    // Bits above WIDTH are masked to zero by misr_next, so folding
    // them into the result leaves the value unchanged.
    if (WIDTH < MISR_MAX_W) begin : g_narrow
        assign sig_next = nxt_w[WIDTH-1:0]
                        | {WIDTH{|nxt_w[MISR_MAX_W-1:WIDTH]}};
    end else begin : g_full
        assign sig_next = nxt_w[WIDTH-1:0];
    end

    // Signature register: seed on load, step on shift.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (shift) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/b01_resp_misr.sv
// b01 response compactor: folds outp/overflw into a MISR for
// TEST_LEN qualified samples, then checks against golden_sig.
module b01_resp_misr
    import bist_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] POLY     = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(DEF_SEED),
    parameter int               TEST_LEN = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sample_en,
    input  logic             outp,
    input  logic             overflw,
    input  logic [WIDTH-1:0] golden_sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    localparam int             CW   = $clog2(TEST_LEN + 1);
    localparam logic [CW-1:0]  LAST = CW'(TEST_LEN - 1);

    bist_state_t      state_q;
    bist_state_t      state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             busy_d;
    logic             done_d;
    logic             pass_d;
    logic             load;
    logic             shift;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] sig_next;

    // Only the two low bits carry b01 response data.
    always_comb begin
        d    = '0;
        d[0] = outp;
        d[1] = overflw;
    end

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .d        (d),
        .sig      (signature),
        .sig_next (sig_next)
    );

    // Control and status registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
            pass    <= pass_d;
        end
    end

    // Next-state: start only from IDLE/DONE, count qualified samples
    // in RUN and latch the compare on the final one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy;
        done_d  = done;
        pass_d  = pass;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (sample_en) begin
                    shift = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (sig_next == golden_sig);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

endmodule
